// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline controller
package pipe_pkg;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } exc_state_e;

    typedef logic [1:0] tval_t;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // True when a D-stage read of addr must wait for a producer that is not ready in time
    function automatic logic raw_hit(
        input logic [4:0] addr,
        input logic [4:0] dst,
        input tval_t      tnew,
        input tval_t      tuse
    );
        return (addr == dst) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multiply/divide busy counter and its D-stage stall
module md_sequencer
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic MdStartE,
    input  logic MdDivE,
    input  logic ExcReqM,
    input  logic MdUseD,
    output logic MdBusy,
    output logic StallMd
);

    logic [3:0] mdcnt;

    // Load on a fresh start that is not killed by an exception; otherwise count down.
    // A running operation is committed and keeps counting regardless of exceptions.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mdcnt <= 4'd0;
        end else if (MdStartE && (mdcnt == 4'd0) && !ExcReqM) begin
            mdcnt <= MdDivE ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (mdcnt != 4'd0) begin
            mdcnt <= mdcnt - 4'd1;
        end
    end

    assign MdBusy  = (mdcnt != 4'd0);
    assign StallMd = MdUseD && (MdBusy || MdStartE);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush control for the five-stage pipeline
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       A1D,
    input  logic [4:0]       A2D,
    input  logic [1:0]       TuseRsD,
    input  logic [1:0]       TuseRtD,
    input  logic             UseRsD,
    input  logic             UseRtD,
    input  logic [4:0]       A3E,
    input  logic [1:0]       TnewE,
    input  logic [4:0]       A3M,
    input  logic [1:0]       TnewM,
    input  logic             MdUseD,
    input  logic             MdStartE,
    input  logic             MdDivE,
    input  logic             ExcReqM,
    output logic             StallF,
    output logic             StallD,
    output logic             DRegFlush,
    output logic             ERegFlush,
    output logic             MRegFlush,
    output logic             WRegFlush,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCnt
);

    exc_state_e state;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       stall;
    logic       exc_take;

    md_sequencer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_sequencer (
        .Clk      (Clk),
        .Reset    (Reset),
        .MdStartE (MdStartE),
        .MdDivE   (MdDivE),
        .ExcReqM  (ExcReqM),
        .MdUseD   (MdUseD),
        .MdBusy   (MdBusy),
        .StallMd  (stall_md)
    );

    assign stall_rs = UseRsD && (A1D != 5'd0) &&
                      (raw_hit(A1D, A3E, TnewE, TuseRsD) || raw_hit(A1D, A3M, TnewM, TuseRsD));
    assign stall_rt = UseRtD && (A2D != 5'd0) &&
                      (raw_hit(A2D, A3E, TnewE, TuseRtD) || raw_hit(A2D, A3M, TnewM, TuseRtD));
    assign stall    = stall_rs || stall_rt || stall_md;

    // A request seen while already in EXC belongs to the flushed stream and is dropped
    assign exc_take = ExcReqM && (state == RUN);

    // Exception flush machine: one RUN->EXC hop per taken exception, always returns next cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= ExcReqM ? EXC : RUN;
                EXC:     state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Flush beats stall; in EXC only the D/E bubble is kept because D's scoreboard view is stale
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        DRegFlush = 1'b0;
        ERegFlush = 1'b0;
        MRegFlush = 1'b0;
        if (exc_take) begin
            DRegFlush = 1'b1;
            ERegFlush = 1'b1;
            MRegFlush = 1'b1;
        end else if (state == EXC) begin
            ERegFlush = 1'b1;
        end else begin
            StallF    = stall;
            StallD    = stall;
            ERegFlush = stall;
        end
    end

    // M commits its exception state, so the M/W register is never cleared here
    assign WRegFlush = 1'b0;

    // Saturating count of cycles with the PC held
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCnt <= '0;
        end else if (StallF && (StallCnt != {CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline controller for the five-stage MIPS core. It computes the stall and flush strobes for the F/D, D/E, E/M and M/W pipeline registers. It owns the multiply/divide busy sequencer and a two-state exception-flush machine. It sits beside the datapath and drives the `*RegFlush` / stall enables of every stage register, including the E/M register's `MRegFlush`.

## Interface

Parameters:
- `MULT_CYC`, default 5: busy cycles for mult/multu.
- `DIV_CYC`, default 10: busy cycles for div/divu.
- `CNT_W`, default 32: width of the stall performance counter.

Ports:
- `Clk` input 1: rising-edge clock, the single clock.
- `Reset` input 1: reset, asynchronous, active-low.
- `A1D`, `A2D` input 5 each: rs and rt read addresses of the instruction in D.
- `TuseRsD`, `TuseRtD` input 2 each: cycles until rs/rt is needed (0 = in D, 1 = in E, 2 = in M).
- `UseRsD`, `UseRtD` input 1 each: the D instruction actually reads rs/rt.
- `A3E`, `TnewE` input 5 / 2: destination and cycles-to-ready of the instruction in E.
- `A3M`, `TnewM` input 5 / 2: destination and cycles-to-ready of the instruction in M.
- `MdUseD` input 1: the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `MdStartE` input 1: the E instruction is a mult/div type.
- `MdDivE` input 1: that operation is div/divu (selects `DIV_CYC`).
- `ExcReqM` input 1: exception, interrupt or eret taken at M.
- `StallF` output 1: hold the PC.
- `StallD` output 1: hold the F/D register.
- `DRegFlush`, `ERegFlush`, `MRegFlush`, `WRegFlush` output 1 each: synchronous clears of the stage registers.
- `MdBusy` output 1: the multiply/divide unit is busy.
- `StallCnt` output `CNT_W`: number of cycles in which `StallF` was asserted.

## Operation

Data-hazard stall (combinational):
- `StallRs` = `UseRsD` && `A1D`≠0 && ((`A1D`==`A3E` && `TnewE`>`TuseRsD`) || (`A1D`==`A3M` && `TnewM`>`TuseRsD`)).
- `StallRt` is the same with `A2D` and `TuseRtD`.
- All Tnew/Tuse comparisons are unsigned 2-bit.

MDU sequencer:
- Holds a 4-bit down-counter `mdcnt`.
- On `MdStartE` && `mdcnt`==0 && !`ExcReqM`: load `DIV_CYC` if `MdDivE`, else `MULT_CYC`.
- Otherwise decrement while nonzero.
- `MdBusy` = (`mdcnt`≠0).
- `StallMd` = `MdUseD` && (`MdBusy` || `MdStartE`).
- An operation already counting is never cancelled by an exception; it is architecturally committed.

Stall = `StallRs` | `StallRt` | `StallMd`. When set: `StallF`=`StallD`=1 and `ERegFlush`=1, inserting a bubble.

Exception FSM, states RUN and EXC:
- RUN→EXC on `ExcReqM`.
- EXC→RUN unconditionally the next cycle.
- In any cycle with `ExcReqM`=1, assert `DRegFlush`, `ERegFlush` and `MRegFlush`. Force `StallF`=`StallD`=0; the flush has priority over the stall.
- `WRegFlush`=0 in that cycle, because M commits its exception state.
- In EXC, stalls are masked (`StallF`/`StallD`=0) and only `ERegFlush` is asserted, because D holds the handler's first fetch with a stale scoreboard.
- `ExcReqM` arriving while in EXC is ignored.

Performance counter:
- `StallCnt` increments by 1 in every cycle where `StallF`=1.
- It saturates at all-ones and never wraps.

## Timing

- Stall and flush outputs are combinational from inputs and state, valid in the same cycle. The stage registers act on the next `Clk` edge.
- MDU latency: an op entering E at edge t gives `MdBusy`=1 for cycles t+1 … t+N, with N = `MULT_CYC` or `DIV_CYC`. An `MdUseD` instruction leaves D at the edge ending cycle t+N.
- A second `MdStartE` while busy does not reload the counter. This cannot occur legally, because `StallMd` prevents it.
- Reset value of every output: `StallF`, `StallD` and all four flush outputs 0, `MdBusy` 0, `StallCnt` 0. Internal state: FSM = RUN, `mdcnt` = 0.
- Reset is asynchronous and active-low. Asserting it mid-operation clears the counter and the FSM immediately.

## Structure

- Shared package `pipe_pkg`:
  - FSM state encoding (RUN/EXC).
  - Tnew/Tuse type (2-bit).
  - Default `MULT_CYC` and `DIV_CYC` constants.
- One sub-module, `md_sequencer`: counter, `MdBusy` and `StallMd`.
- Hazard comparators, exception FSM and `StallCnt` stay in the top level.

## Test plan

- **RAW stall.** Drive `A3E`=5, `TnewE`=2, `A1D`=5, `UseRsD`=1, `TuseRsD`=0. Expect `StallF`=`StallD`=`ERegFlush`=1. With `A1D`=0 instead, expect no stall.
- **mult then mflo.** Pulse `MdStartE` with `MdDivE`=0, holding `MdUseD`=1 throughout. Expect:
  - `MdBusy` high for exactly 5 cycles.
  - `StallF` high for 6 cycles (the start cycle plus 5 busy cycles).
  - `StallCnt`=6.
- **Exception during stall.** Set `ExcReqM`=1 together with a RAW hazard. Expect `StallF`=0 and `DRegFlush`=`ERegFlush`=`MRegFlush`=1 for one cycle. The next cycle (EXC) expect `ERegFlush`=1 and `StallF`=0.
- **Exception vs. MDU start.** Assert `MdStartE` and `ExcReqM` in the same cycle: `MdBusy` stays 0. Assert `ExcReqM` 3 cycles into a div: `MdBusy` stays high through cycle 10.
- **Reset mid-div.** Drop `Reset` to 0 on cycle 4 of a div. Expect `MdBusy`=0 immediately and all outputs at their reset values.
- **Counter saturation.** With `CNT_W`=4, hold a stall for 20 cycles. Expect `StallCnt`=15 with no wrap.
